// File: rtl/ctr_record_buffer.sv
// ctr_record_buffer
//   Receive side of the control-transfer-record emitter interface. Each
//   emitted record (source, target, type) that passes the privilege filter
//   and the freeze control is written into a circular buffer of DEPTH
//   entries at the write pointer, which then advances (wrapping overwrites
//   the oldest record). A multi-cycle sequencer invalidates the whole buffer
//   on request. The CSR side reads records newest-first through a registered
//   indexed port and can read and overwrite the write pointer.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   rec_source_i            {pc[XLEN-1:1], v}; v = 1 marks an emitted record
//   rec_target_i            {pc[XLEN-1:1], misp}
//   rec_type_i              transfer type (0 = none)
//   rec_priv_i              privilege of the source instruction (0 U, 1 S, 3 M)
//   en_m_i, en_s_i, en_u_i  record enable per privilege level
//   frz_i                   freeze: nothing is captured while high
//   clr_i                   single-cycle clear request
//   busy_o                  clear sequence in progress
//   rd_req_i, rd_idx_i,     read request; index 0 is the newest record;
//   rd_sel_i                sel 0 source, 1 target, 2 data, 3 reserved
//   rd_valid_o, rd_data_o   read response, exactly one cycle after rd_req_i;
//                           rd_data_o holds its value between responses
//   wrptr_o                 current write pointer
//   wrptr_we_i, wrptr_wdata_i  write-pointer load (honoured only when idle)
//
// Read handshake: rd_req_i is sampled on a rising edge; on the following
// cycle rd_valid_o is high for exactly one cycle per request, with
// rd_data_o carrying the answer. There is no back-pressure.
module ctr_record_buffer #(
   parameter  int XLEN  = 64,
   parameter  int DEPTH = 16,
   localparam int IdxW  = $clog2(DEPTH)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] rec_source_i,
   input  logic [XLEN-1:0] rec_target_i,
   input  logic [3:0]      rec_type_i,
   input  logic [1:0]      rec_priv_i,
   input  logic            en_m_i,
   input  logic            en_s_i,
   input  logic            en_u_i,
   input  logic            frz_i,
   input  logic            clr_i,
   output logic            busy_o,
   input  logic            rd_req_i,
   input  logic [IdxW-1:0] rd_idx_i,
   input  logic [1:0]      rd_sel_i,
   output logic            rd_valid_o,
   output logic [XLEN-1:0] rd_data_o,
   output logic [IdxW-1:0] wrptr_o,
   input  logic            wrptr_we_i,
   input  logic [IdxW-1:0] wrptr_wdata_i
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [IdxW-1:0] cnt_q, cnt_d;
   logic [IdxW-1:0] wrptr_q;
   logic [DEPTH-1:0] valid_q;

   // Record storage carries no reset: the valid bits alone decide what
   // is visible, so stale contents can never reach the read port.
   logic [XLEN-1:0] src_mem [DEPTH];
   logic [XLEN-1:0] tgt_mem [DEPTH];
   logic [3:0]      type_mem [DEPTH];

   logic            rd_valid_q;
   logic [XLEN-1:0] rd_data_q;

   logic            priv_en;
   logic            idle;
   logic            capture;
   logic            last_clear;
   logic [IdxW-1:0] rd_slot;
   logic [XLEN-1:0] rd_word;

   // ---------------------------------------------------------------
   // Capture qualification
   // ---------------------------------------------------------------
   always_comb begin
      priv_en = 1'b0;
      case (rec_priv_i)
         2'd0:    priv_en = en_u_i;
         2'd1:    priv_en = en_s_i;
         2'd3:    priv_en = en_m_i;
         default: priv_en = 1'b0;   // priv 2 is never recorded
      endcase
   end

   assign idle       = (state_q == ST_IDLE);
   // A same-cycle pointer write takes precedence and drops the record.
   assign capture    = rec_source_i[0] & ~frz_i & priv_en & idle & ~wrptr_we_i;
   assign last_clear = (state_q == ST_CLEAR) && (cnt_q == IdxW'(DEPTH - 1));

   // ---------------------------------------------------------------
   // Clear sequencer
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_i) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            cnt_d = cnt_q + IdxW'(1);
            if (last_clear) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o = (state_q == ST_CLEAR);

   // ---------------------------------------------------------------
   // Write pointer and valid bits
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wrptr_q <= '0;
      end else if (last_clear) begin
         wrptr_q <= '0;
      end else if (idle && wrptr_we_i) begin
         wrptr_q <= wrptr_wdata_i;
      end else if (capture) begin
         wrptr_q <= wrptr_q + IdxW'(1);
      end
   end

   // Capture only happens in IDLE and clearing only in CLEAR, so the
   // set and the clear never hit the valid vector in the same cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else if (state_q == ST_CLEAR) begin
         valid_q[cnt_q] <= 1'b0;
      end else if (capture) begin
         valid_q[wrptr_q] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (capture) begin
         src_mem[wrptr_q]  <= rec_source_i;
         tgt_mem[wrptr_q]  <= rec_target_i;
         type_mem[wrptr_q] <= rec_type_i;
      end
   end

   assign wrptr_o = wrptr_q;

   // ---------------------------------------------------------------
   // Read port: newest-first index mapped onto the physical slot using
   // the pointer before any same-cycle update; IdxW-bit arithmetic
   // provides the modulo-DEPTH wrap.
   // ---------------------------------------------------------------
   assign rd_slot = wrptr_q - IdxW'(1) - rd_idx_i;

   always_comb begin
      rd_word = '0;
      if (idle && valid_q[rd_slot]) begin
         case (rd_sel_i)
            2'd0:    rd_word = {src_mem[rd_slot][XLEN-1:1], valid_q[rd_slot]};
            2'd1:    rd_word = tgt_mem[rd_slot];
            2'd2:    rd_word = {{(XLEN-4){1'b0}}, type_mem[rd_slot]};
            default: rd_word = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_req_i;
         if (rd_req_i) begin
            rd_data_q <= rd_word;
         end
      end
   end

   assign rd_valid_o = rd_valid_q;
   assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_ctr_record_buffer.sv
// tb_ctr_record_buffer
//   Directed bench for ctr_record_buffer with hand-computed expectations:
//   capture and newest-first reads, wrap-around, privilege/freeze filtering,
//   the clear sequence, pointer writes racing a record, and reset mid-clear.
module tb_ctr_record_buffer;

   localparam int XLEN  = 64;
   localparam int DEPTH = 16;
   localparam int IdxW  = $clog2(DEPTH);

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] rec_source;
   logic [XLEN-1:0] rec_target;
   logic [3:0]      rec_type;
   logic [1:0]      rec_priv;
   logic            en_m, en_s, en_u;
   logic            frz;
   logic            clr;
   logic            busy;
   logic            rd_req;
   logic [IdxW-1:0] rd_idx;
   logic [1:0]      rd_sel;
   logic            rd_valid;
   logic [XLEN-1:0] rd_data;
   logic [IdxW-1:0] wrptr;
   logic            wrptr_we;
   logic [IdxW-1:0] wrptr_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   ctr_record_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .rec_source_i  (rec_source),
      .rec_target_i  (rec_target),
      .rec_type_i    (rec_type),
      .rec_priv_i    (rec_priv),
      .en_m_i        (en_m),
      .en_s_i        (en_s),
      .en_u_i        (en_u),
      .frz_i         (frz),
      .clr_i         (clr),
      .busy_o        (busy),
      .rd_req_i      (rd_req),
      .rd_idx_i      (rd_idx),
      .rd_sel_i      (rd_sel),
      .rd_valid_o    (rd_valid),
      .rd_data_o     (rd_data),
      .wrptr_o       (wrptr),
      .wrptr_we_i    (wrptr_we),
      .wrptr_wdata_i (wrptr_wdata)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [XLEN-1:0] got,
                        input logic [XLEN-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Inputs change and outputs are sampled 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rec_source  = '0;
      rec_target  = '0;
      rec_type    = '0;
      rec_priv    = 2'd3;
      en_m        = 1'b1;
      en_s        = 1'b1;
      en_u        = 1'b1;
      frz         = 1'b0;
      clr         = 1'b0;
      rd_req      = 1'b0;
      rd_idx      = '0;
      rd_sel      = '0;
      wrptr_we    = 1'b0;
      wrptr_wdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One record for one cycle; pc has bit 0 clear, v is set here.
   task automatic push(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                       input logic [3:0] typ, input logic [1:0] priv);
      rec_source = pc | 64'h1;
      rec_target = tgt;
      rec_type   = typ;
      rec_priv   = priv;
      tick();
      rec_source = '0;
   endtask

   task automatic read_check(input string tag, input int idx, input int sel,
                             input logic [XLEN-1:0] exp);
      rd_req = 1'b1;
      rd_idx = IdxW'(idx);
      rd_sel = 2'(sel);
      tick();
      rd_req = 1'b0;
      check({tag, "_valid"}, XLEN'(rd_valid), XLEN'(1));
      check(tag, rd_data, exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int busy_cycles;
      int nonzero;

      idle_inputs();
      rst = 1'b1;
      #2;
      check("rst_busy",    XLEN'(busy), '0);
      check("rst_rdvalid", XLEN'(rd_valid), '0);
      check("rst_rddata",  rd_data, '0);
      check("rst_wrptr",   XLEN'(wrptr), '0);
      tick();
      rst = 1'b0;

      // 1: three M-mode records
      push(64'h100, 64'h1000, 4'd1, 2'd3);
      push(64'h200, 64'h2000, 4'd2, 2'd3);
      push(64'h300, 64'h3000, 4'd3, 2'd3);
      check("t1_wrptr", XLEN'(wrptr), XLEN'(3));
      read_check("t1_idx0_src", 0, 0, 64'h301);
      tick();
      check("t1_hold_valid", XLEN'(rd_valid), '0);
      check("t1_hold_data",  rd_data, 64'h301);
      read_check("t1_idx2_tgt",  2, 1, 64'h1000);
      read_check("t1_idx1_type", 1, 2, 64'h2);
      read_check("t1_idx0_rsvd", 0, 3, 64'h0);
      read_check("t1_idx5_inv",  5, 0, 64'h0);

      // 2: wrap-around with 18 records
      do_reset();
      for (int n = 0; n < DEPTH + 2; n++)
         push(XLEN'(16 * n), XLEN'(32'h8000 + 16 * n), 4'(n), 2'd3);
      check("t2_wrptr", XLEN'(wrptr), XLEN'(2));
      read_check("t2_idx0_src",  0,  0, 64'h111);
      read_check("t2_idx0_tgt",  0,  1, 64'h8110);
      read_check("t2_idx1_src",  1,  0, 64'h101);
      read_check("t2_idx15_src", 15, 0, 64'h21);
      read_check("t2_idx15_typ", 15, 2, 64'h2);

      // 3: privilege filter and freeze
      do_reset();
      en_u = 1'b0;
      push(64'h400, 64'h4000, 4'd1, 2'd0);   // U, disabled
      push(64'h500, 64'h5000, 4'd1, 2'd1);   // S, stored
      frz = 1'b1;
      push(64'h600, 64'h6000, 4'd1, 2'd1);   // frozen
      frz = 1'b0;
      push(64'h700, 64'h7000, 4'd1, 2'd2);   // priv 2
      en_m = 1'b0;
      push(64'h800, 64'h8000, 4'd1, 2'd3);   // M, disabled
      check("t3_wrptr", XLEN'(wrptr), XLEN'(1));
      read_check("t3_idx0_src", 0, 0, 64'h501);
      read_check("t3_idx1_inv", 1, 0, 64'h0);
      en_m = 1'b1;
      en_u = 1'b1;

      // 4: clear sequence
      do_reset();
      for (int n = 0; n < 4; n++)
         push(XLEN'(64'h1000 + 16 * n), 64'h9000, 4'd5, 2'd3);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 40 && busy; i++) begin
         if (i == 1) begin
            rd_req = 1'b1;          // newest slot 3 still valid at this edge
            rd_idx = '0;
            rd_sel = '0;
         end
         if (i == 2) begin
            rd_req = 1'b0;
            check("t4_midclr_rdvalid", XLEN'(rd_valid), XLEN'(1));
            check("t4_midclr_rddata",  rd_data, '0);
         end
         if (i == 3) begin
            rec_source = 64'hA001;
            rec_priv   = 2'd3;
         end
         if (i == 4) rec_source = '0;
         tick();
         busy_cycles++;
      end
      check("t4_busy_cycles", XLEN'(busy_cycles), XLEN'(DEPTH));
      check("t4_wrptr",       XLEN'(wrptr), '0);
      nonzero = 0;
      for (int idx = 0; idx < DEPTH; idx++) begin
         for (int sel = 0; sel < 4; sel++) begin
            rd_req = 1'b1;
            rd_idx = IdxW'(idx);
            rd_sel = 2'(sel);
            tick();
            if (rd_data != '0) nonzero++;
         end
      end
      rd_req = 1'b0;
      check("t4_all_zero", XLEN'(nonzero), '0);

      // 5: pointer write racing a record
      do_reset();
      push(64'h900, 64'h9900, 4'd4, 2'd3);    // slot 0
      wrptr_we    = 1'b1;
      wrptr_wdata = IdxW'(5);
      push(64'hA00, 64'hAA00, 4'd4, 2'd3);    // dropped
      wrptr_we    = 1'b0;
      check("t5_wrptr_load", XLEN'(wrptr), XLEN'(5));
      read_check("t5_slot4_inv", 0, 0, 64'h0);
      push(64'hB00, 64'hBB00, 4'd6, 2'd3);    // slot 5
      check("t5_wrptr_next", XLEN'(wrptr), XLEN'(6));
      read_check("t5_idx0_src",  0, 0, 64'hB01);
      read_check("t5_slot1_inv", 4, 0, 64'h0);
      read_check("t5_slot0_src", 5, 0, 64'h901);

      // 6: reset in the middle of a clear
      do_reset();
      push(64'hC00, 64'hCC00, 4'd1, 2'd3);
      push(64'hD00, 64'hDD00, 4'd1, 2'd3);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      rd_req = 1'b1;
      tick();                                 // 7th busy cycle, read issued
      rd_req = 1'b0;
      check("t6_pre_busy",    XLEN'(busy), XLEN'(1));
      check("t6_pre_rdvalid", XLEN'(rd_valid), XLEN'(1));
      check("t6_pre_wrptr",   XLEN'(wrptr), XLEN'(2));
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_busy",    XLEN'(busy), '0);
      check("t6_rst_rdvalid", XLEN'(rd_valid), '0);
      check("t6_rst_wrptr",   XLEN'(wrptr), '0);
      tick();
      rst = 1'b0;
      push(64'hE00, 64'hEE00, 4'd2, 2'd3);
      check("t6_resume_wrptr", XLEN'(wrptr), XLEN'(1));
      read_check("t6_resume_src", 0, 0, 64'hE01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ctr_record_buffer.md
Name: ctr_record_buffer

Overview:
- Receive side of the control-transfer-record emitter interface.
- Captures each emitted record (source, target, type) into a circular buffer of DEPTH entries, with filtering by privilege and a freeze control.
- Exposes a registered, newest-first indexed read port and a write-pointer register for the CSR file (sctrstatus/sireg-style access).
- Provides a multi-cycle clear sequencer that invalidates the whole buffer.

Parameters:
- XLEN, 64, data width of the source, target and read-data words.
- DEPTH, 16, number of record entries; power of two, 2..256.
- IdxW, $clog2(DEPTH), width of the index and pointer fields (derived, not overridable).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- rec_source_i  in  XLEN  emitted source word: [XLEN-1:1] pc, [0] v (record-valid).
- rec_target_i  in  XLEN  emitted target word: [XLEN-1:1] pc, [0] misp.
- rec_type_i  in  4  emitted transfer type (CTR type encoding; 0 = none).
- rec_priv_i  in  2  privilege level of the source instruction (0 U, 1 S, 3 M).
- en_m_i / en_s_i / en_u_i  in  1 each  record-enable per privilege level.
- frz_i  in  1  freeze; no records are captured while it is high.
- clr_i  in  1  single-cycle clear request.
- busy_o  out  1  clear sequence in progress.
- rd_req_i  in  1  read request.
- rd_idx_i  in  IdxW  logical index; 0 = newest record.
- rd_sel_i  in  2  0 source, 1 target, 2 data, 3 reserved.
- rd_valid_o  out  1  read response valid.
- rd_data_o  out  XLEN  read response data.
- wrptr_o  out  IdxW  current write pointer.
- wrptr_we_i  in  1  write strobe for the write pointer.
- wrptr_wdata_i  in  IdxW  new write-pointer value.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - all entry valid bits cleared; wrptr = 0; FSM = IDLE.
  - busy_o = 0, rd_valid_o = 0, rd_data_o = 0.
  - A reset asserted mid-clear aborts the clear; the FSM returns to IDLE.
- Capture condition: rec_source_i[0] & ~frz_i & priv_en & (state == IDLE) & ~wrptr_we_i.
  - priv_en = en_m_i for priv 3, en_s_i for priv 1, en_u_i for priv 0; priv 2 never captures.
- On capture, entry[wrptr] takes {source, target, type}, its valid bit is set, and wrptr becomes wrptr + 1 mod DEPTH. Wrap from DEPTH-1 to 0 silently overwrites the oldest entry.
- Records are accepted back-to-back, one per cycle.
- wrptr_we_i is honoured only in IDLE and loads wrptr_wdata_i; entries are unchanged. If a record arrives in the same cycle, the pointer write wins and the record is dropped.
- Read port:
  - Latency is exactly 1 cycle: rd_valid_o = registered rd_req_i.
  - Physical slot = (wrptr - 1 - rd_idx_i) mod DEPTH, using wrptr as it stands before any same-cycle update.
  - Data by rd_sel_i:
    - sel 0 returns {pc, v}, with v = the entry valid bit.
    - sel 1 returns the stored target word.
    - sel 2 returns zero-extended {type[3:0]}, cycle-count fields 0.
    - sel 3 returns 0.
  - An invalid slot returns 0 for every sel.
  - rd_data_o holds its last value when rd_valid_o = 0.
- Clear FSM:
  - IDLE: clr_i moves to CLEAR with cnt = 0 and busy_o = 1 from the next cycle.
  - CLEAR: clears valid[cnt] each cycle and increments cnt. After clearing slot DEPTH-1, sets wrptr = 0 and returns to IDLE; busy_o drops in that same transition.
  - Total busy duration is DEPTH cycles.
  - In CLEAR, records and wrptr writes are dropped and clr_i is ignored.
  - A read issued during CLEAR is answered normally, with data 0.
- If clr_i and a capture occur in the same IDLE cycle, the record is written, then cleared by the sequence.

Test Plan:
- Reset, en_m=1, push 3 M-mode records with pc 0x100/0x200/0x300 → wrptr=3. Read idx0 sel0 → next cycle rd_valid=1, data=0x301. Read idx2 sel1 → target of the first record.
- Push DEPTH+2 = 18 records with source pc = 0x10·n → wrptr=2. idx0 returns pc 0x110 (n=17); idx15 returns pc 0x20 (n=2); n=0 and n=1 are overwritten.
- en_u=0, en_s=1: push a U record, then an S record, then an S record with frz_i=1 → only the first S record is stored, wrptr advances by 1; priv=2 record → dropped.
- Fill 4 entries, pulse clr_i → busy_o high for 16 cycles. A record mid-clear is dropped. Afterwards wrptr=0 and every idx/sel reads 0.
- wrptr_we_i with wdata=5 in the same cycle as a valid record → wrptr=5, no entry written. Next record lands in slot 5 and reads back at idx0.
- Assert rst_i mid-clear (cycle 7) → busy_o=0, rd_valid_o=0 and wrptr=0 immediately. Capture resumes on the first cycle after reset deasserts.
